// File: rtl/enigma_rotor_sequencer.sv
// enigma_rotor_sequencer
//
// Carries one character at a time through a three-rotor Enigma chain. Three
// rotor position registers step odometer-style on every accepted letter, and
// a single external combinational letter_shifter is time-multiplexed across
// the three rotor stages (one stage per cycle).
//
// Ports:
//   clock, resetn          system clock (rising edge), async active-low reset
//   load_en, load_pos      load {r2,r1,r0} (7 bits each), honoured in IDLE only
//   in_valid, in_ready     input handshake; in_char is the letter index,
//   in_char, in_encrypt    in_encrypt selects add (1) or subtract (0)
//   out_valid, out_ready   output handshake; out_char held while out_valid
//   out_char
//   rotor_pos              current {r2,r1,r0}
//   shift_char/rotor/      operands to the external letter_shifter,
//   shift_encrypt          zero outside the PASS states
//   shift_result           letter_shifter result, bits [6:0] used
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a character or a rotor load
// PASS0 | shifter operating on work with r0
// PASS1 | shifter operating on work with r1
// PASS2 | shifter operating on work with r2, result goes to out_char
// DONE  | out_valid high, waiting for out_ready

module enigma_rotor_sequencer #(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load_en,
  input  logic [20:0] load_pos,
  input  logic        in_valid,
  input  logic [6:0]  in_char,
  input  logic        in_encrypt,
  output logic        in_ready,
  output logic        out_valid,
  output logic [6:0]  out_char,
  input  logic        out_ready,
  output logic [20:0] rotor_pos,
  output logic [6:0]  shift_char,
  output logic [6:0]  shift_rotor,
  output logic        shift_encrypt,
  input  logic [7:0]  shift_result
);

  if (NUM_ROTORS != 3) begin : g_bad_rotors
    $error("enigma_rotor_sequencer supports only NUM_ROTORS = 3");
  end

  localparam logic [6:0] LAST = 7'(ALPHA - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PASS0 = 3'd1,
    S_PASS1 = 3'd2,
    S_PASS2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [6:0]  r0_q, r1_q, r2_q;
  logic [6:0]  work_q;
  logic [6:0]  out_char_q;
  logic        out_valid_q;
  logic [6:0]  shift_char_q;
  logic [6:0]  shift_rotor_q;
  logic        shift_enc_q;

  // Stepped rotor positions (odometer carry chain).
  logic [6:0]  r0_d, r1_d, r2_d;
  logic        r0_wrap, r1_wrap;

  logic [6:0]  res;
  logic        is_letter;
  logic        idle;
  logic        unused_shift_msb;

  assign res              = shift_result[6:0];
  assign unused_shift_msb = shift_result[7];
  assign is_letter        = (in_char <= LAST);
  assign idle             = (state_q == S_IDLE);

  always_comb begin
    r0_wrap = (r0_q == LAST);
    r1_wrap = (r1_q == LAST);
    r0_d    = r0_wrap ? 7'd0 : r0_q + 7'd1;
    r1_d    = r1_q;
    r2_d    = r2_q;
    if (r0_wrap) begin
      r1_d = r1_wrap ? 7'd0 : r1_q + 7'd1;
      if (r1_wrap) begin
        r2_d = (r2_q == LAST) ? 7'd0 : r2_q + 7'd1;
      end
    end
  end

  // Out-of-range load fields are forced to 0 so the rotors always hold 0..25.
  function automatic logic [6:0] clamp_pos(input logic [6:0] f);
    return (f > LAST) ? 7'd0 : f;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      r0_q          <= 7'd0;
      r1_q          <= 7'd0;
      r2_q          <= 7'd0;
      work_q        <= 7'd0;
      out_char_q    <= 7'd0;
      out_valid_q   <= 1'b0;
      shift_char_q  <= 7'd0;
      shift_rotor_q <= 7'd0;
      shift_enc_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_en) begin
            r0_q <= clamp_pos(load_pos[6:0]);
            r1_q <= clamp_pos(load_pos[13:7]);
            r2_q <= clamp_pos(load_pos[20:14]);
          end else if (in_valid) begin
            if (is_letter) begin
              work_q        <= in_char;
              r0_q          <= r0_d;
              r1_q          <= r1_d;
              r2_q          <= r2_d;
              // Shifter operands are registered one cycle ahead so they are
              // already presented during PASS0 (rotor uses the stepped r0).
              shift_char_q  <= in_char;
              shift_rotor_q <= r0_d;
              shift_enc_q   <= in_encrypt;
              state_q       <= S_PASS0;
            end else begin
              out_char_q    <= in_char;
              out_valid_q   <= 1'b1;
              state_q       <= S_DONE;
            end
          end
        end

        S_PASS0: begin
          work_q        <= res;
          shift_char_q  <= res;
          shift_rotor_q <= r1_q;
          state_q       <= S_PASS1;
        end

        S_PASS1: begin
          work_q        <= res;
          shift_char_q  <= res;
          shift_rotor_q <= r2_q;
          state_q       <= S_PASS2;
        end

        S_PASS2: begin
          work_q        <= res;
          out_char_q    <= res;
          out_valid_q   <= 1'b1;
          shift_char_q  <= 7'd0;
          shift_rotor_q <= 7'd0;
          shift_enc_q   <= 1'b0;
          state_q       <= S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q       <= S_IDLE;
          out_valid_q   <= 1'b0;
          shift_char_q  <= 7'd0;
          shift_rotor_q <= 7'd0;
          shift_enc_q   <= 1'b0;
        end
      endcase
    end
  end

  // in_ready drops combinationally with load_en so a load always wins.
  assign in_ready      = idle & ~load_en;
  assign out_valid     = out_valid_q;
  assign out_char      = out_char_q;
  assign rotor_pos     = {r2_q, r1_q, r0_q};
  assign shift_char    = shift_char_q;
  assign shift_rotor   = shift_rotor_q;
  assign shift_encrypt = shift_enc_q;

endmodule

// File: doc/enigma_rotor_sequencer.md
# enigma_rotor_sequencer

Controller that carries one character at a time through a three-rotor Enigma chain. It steps three rotor position registers odometer-style and time-multiplexes a single combinational `letter_shifter` datapath across the three rotor stages. It sits between the character source (keyboard/text buffer) and the display/output buffer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `NUM_ROTORS`, 3: number of rotor stages. Fixed at 3 in this revision; only 3 is supported.
- `ALPHA`, 26: alphabet size. Rotor positions wrap at `ALPHA-1`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  load rotor positions from `load_pos`. Honoured only in IDLE.
- `load_pos`  in  21  `{r2,r1,r0}`, 7 bits each.
- `in_valid`  in  1  character offered.
- `in_char`  in  7  letter index (0..25 = A..Z). Values above 25 are non-letters.
- `in_encrypt`  in  1  1 = encrypt (shifter adds), 0 = decrypt (shifter subtracts).
- `in_ready`  out  1  the block accepts a character this cycle.
- `out_valid`  out  1  result held.
- `out_char`  out  7  result character.
- `out_ready`  in  1  consumer takes the result.
- `rotor_pos`  out  21  current `{r2,r1,r0}`.
- `shift_char`  out  7  to `letter_shifter.char_input`.
- `shift_rotor`  out  7  to `letter_shifter.rotor_value`.
- `shift_encrypt`  out  1  to `letter_shifter.encrypt`.
- `shift_result`  in  8  from `letter_shifter.letter_out`. Only bits [6:0] are used.

## Operation
- States: IDLE, PASS0, PASS1, PASS2, DONE.
- **IDLE**
  - `in_ready = ~load_en`.
  - `load_en=1`: each field loads into its rotor register; any field greater than 25 loads 0. The state stays IDLE. Load beats `in_valid` in the same cycle.
  - `in_valid & in_ready` with a letter:
    - latch the character into `work` and the mode.
    - step the rotors: r0 += 1. If r0 wraps 25→0, r1 += 1. If r1 also wraps, r2 += 1 (wraps 25→0).
    - go to PASS0.
  - `in_valid & in_ready` with a non-letter (greater than 25):
    - latch it into `out_char` unchanged.
    - no rotor step.
    - go to DONE.
- **PASSn** (n = 0, 1, 2)
  - drive `shift_char = work`, `shift_rotor = rn` (post-step value), `shift_encrypt = latched mode`.
  - at the clock edge, `work <= shift_result[6:0]`.
  - PASS0→PASS1→PASS2→DONE. PASS2 writes `out_char`.
- **DONE**
  - `out_valid = 1`; `out_char` is held stable.
  - on `out_ready`, go to IDLE.
- Shifter outputs are driven to 0 outside the PASS states.
- `load_en`, `in_valid` and `in_char` are ignored outside IDLE.
- Arithmetic: the rotor registers are 7 bits and always hold 0..25. Modular add and subtract are done by the shifter, and the block does not re-check its result.
- Net effect on a letter: encrypt gives (c + r0 + r1 + r2) mod 26 and decrypt gives the inverse, using post-step positions.

## Timing
- Reset (asynchronous, `resetn=0`):
  - state IDLE, r0 = r1 = r2 = 0, `work = 0`.
  - `out_valid = 0`, `out_char = 0`, `in_ready = 1`.
  - all `shift_*` outputs 0.
  - An in-flight character is discarded.
- Letter accepted at edge k:
  - `rotor_pos` shows the stepped value after edge k.
  - PASS0, PASS1 and PASS2 occupy cycles k+1..k+3.
  - `out_valid` is high from edge k+4. Latency is 4 cycles.
- Non-letter accepted at edge k: `out_valid` is high from edge k+1.
- DONE with `out_ready=1`:
  - `out_valid` falls at the next edge and `in_ready` rises then.
  - There is no overlap with the next accept. Peak throughput is one letter per 5 cycles.
- Backpressure: DONE is held indefinitely, with `out_char`, `rotor_pos` and `in_ready=0` all stable.

## Test plan
- Reset, then load {0,0,0}; encrypt 0 ('A') → `rotor_pos` = {0,0,1}, `out_char` = 1 at accept+4.
- Load {7,3,25}; encrypt 4 → positions {7,4,0}, `out_char` = 15. Then load {7,3,25}; decrypt 15 → `out_char` = 4.
- Load {25,25,25}; encrypt 0 → positions {0,0,0}, `out_char` = 0. This is a full odometer wrap.
- Load with field 30 in r1 → r1 reads 0. Assert `load_en` and `in_valid` in the same cycle → no accept, load applied.
- Non-letter 30 → `out_char` = 30 at accept+1, `rotor_pos` unchanged. Hold `out_ready=0` for 10 cycles → outputs stable, `in_ready=0`.
- Drop `resetn` during PASS1 → immediate IDLE, all outputs at reset values. The next encrypt of 0 with positions {0,0,0} yields 1.
